exec_sequencer: RTL

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_pkg.sv | 15 +
 rtl/exec_sequencer_if.sv | 33 +++
 rtl/edge_rise.sv | 24 ++
 rtl/exec_sequencer_core.sv | 107 ++++++++++
 rtl/exec_sequencer.sv | 56 +++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared encodings for the execution sequencer: FSM state values and the
// default program-counter reset vector.
package exec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_STEP = 3'd2,
        ST_HALT = 3'd3,
        ST_EXC  = 3'd4
    } state_t;

    localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

endpackage

// File: rtl/exec_sequencer_if.sv
// Control/status bundle between the front-panel/datapath side (master) and the
// sequencer core (slave).
interface exec_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             step;
    logic             load;
    logic [7:0]       pc_val;
    logic             resume;
    logic [7:0]       next_pc;
    logic             exc;
    logic             bp_en;
    logic [7:0]       bp_addr;

    logic [7:0]       pc;
    logic             commit;
    logic [7:0]       epc;
    logic [2:0]       state;
    logic             halted;
    logic             exc_led;
    logic [CNT_W-1:0] icount;

    modport master (
        output run, step, load, pc_val, resume, next_pc, exc, bp_en, bp_addr,
        input  pc, commit, epc, state, halted, exc_led, icount
    );

    modport slave (
        input  run, step, load, pc_val, resume, next_pc, exc, bp_en, bp_addr,
        output pc, commit, epc, state, halted, exc_led, icount
    );
endinterface

// File: rtl/edge_rise.sv
// Rising-edge detector for a synchronous, debounced level input. Edges are
// suppressed on the first clock after reset so a held input never fires.
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);
    logic prev;
    logic armed;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= sig;
            armed <= 1'b1;
        end
    end

    assign rise = sig & ~prev & armed;
endmodule

// File: rtl/exec_sequencer_core.sv
// Run/step/halt/exception sequencer: owns the PC, exception PC and the
// retired-instruction counter, and gates datapath commits.
module exec_sequencer_core
    import exec_pkg::*;
#(
    parameter logic [7:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int         CNT_W    = 16
) (
    input logic             clk,
    input logic             rst,
    exec_sequencer_if.slave bus
);
    state_t           state, state_n;
    logic [7:0]       pc, pc_n;
    logic [7:0]       epc, epc_n;
    logic [CNT_W-1:0] icount, icount_n;
    logic             step_rise;
    logic             resume_rise;
    logic             commit;

    edge_rise u_step_edge   (.clk(clk), .rst(rst), .sig(bus.step),   .rise(step_rise));
    edge_rise u_resume_edge (.clk(clk), .rst(rst), .sig(bus.resume), .rise(resume_rise));

    // An exception in the executing cycle squashes that instruction's writes.
    assign commit = ((state == ST_RUN) || (state == ST_STEP)) && !bus.exc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            epc    <= 8'h00;
            icount <= '0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            epc    <= epc_n;
            icount <= icount_n;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch behind.
        state_n  = state;
        pc_n     = pc;
        epc_n    = epc;
        icount_n = icount;
        if (commit) begin
            pc_n     = bus.next_pc;
            icount_n = icount + CNT_W'(1);
        end
        case (state)
            ST_IDLE: begin
                if (bus.load) begin
                    pc_n     = bus.pc_val;
                    icount_n = '0;
                end else if (step_rise) begin
                    state_n = ST_STEP;
                end else if (bus.run) begin
                    state_n = ST_RUN;
                end
            end
            ST_STEP: begin
                if (bus.exc) begin
                    epc_n   = pc;
                    state_n = ST_EXC;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.exc) begin
                    epc_n   = pc;
                    state_n = ST_EXC;
                end else if (bus.bp_en && (bus.next_pc == bus.bp_addr)) begin
                    state_n = ST_HALT;
                end else if (!bus.run) begin
                    state_n = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (step_rise) begin
                    state_n = ST_STEP;
                end else if (!bus.run) begin
                    state_n = ST_IDLE;
                end
            end
            ST_EXC: begin
                if (bus.load) begin
                    pc_n    = bus.pc_val;
                    state_n = ST_IDLE;
                end else if (resume_rise) begin
                    pc_n    = epc + 8'd1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.pc      = pc;
    assign bus.commit  = commit;
    assign bus.epc     = epc;
    assign bus.state   = state;
    assign bus.halted  = (state == ST_HALT) || (state == ST_EXC);
    assign bus.exc_led = (state == ST_EXC);
    assign bus.icount  = icount;
endmodule

// File: rtl/exec_sequencer.sv
// Execution sequencer top: exposes the flat ES_* pins and routes them through
// the control/status interface into the sequencer core.
module exec_sequencer
    import exec_pkg::*;
#(
    parameter logic [7:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int         CNT_W    = 16
) (
    input  logic             ES_clk,
    input  logic             ES_rst,
    input  logic             ES_run,
    input  logic             ES_step,
    input  logic             ES_load,
    input  logic [7:0]       ES_pc_val,
    input  logic             ES_resume,
    input  logic [7:0]       ES_next_pc,
    input  logic             ES_exc,
    input  logic             ES_bp_en,
    input  logic [7:0]       ES_bp_addr,
    output logic [7:0]       ES_pc,
    output logic             ES_commit,
    output logic [7:0]       ES_epc,
    output logic [2:0]       ES_state,
    output logic             ES_halted,
    output logic             ES_exc_led,
    output logic [CNT_W-1:0] ES_icount
);
    exec_sequencer_if #(.CNT_W(CNT_W)) bus ();

    assign bus.run     = ES_run;
    assign bus.step    = ES_step;
    assign bus.load    = ES_load;
    assign bus.pc_val  = ES_pc_val;
    assign bus.resume  = ES_resume;
    assign bus.next_pc = ES_next_pc;
    assign bus.exc     = ES_exc;
    assign bus.bp_en   = ES_bp_en;
    assign bus.bp_addr = ES_bp_addr;

    exec_sequencer_core #(
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W)
    ) u_core (
        .clk (ES_clk),
        .rst (ES_rst),
        .bus (bus.slave)
    );

    assign ES_pc      = bus.pc;
    assign ES_commit  = bus.commit;
    assign ES_epc     = bus.epc;
    assign ES_state   = bus.state;
    assign ES_halted  = bus.halted;
    assign ES_exc_led = bus.exc_led;
    assign ES_icount  = bus.icount;
endmodule
